// File: rtl/riscv_pkg.sv
// riscv_pkg: fetch FSM state encodings, NOP constant and opcodes shared with the control unit.
package riscv_pkg;
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [6:0]  OP_LOAD   = 7'h03;
    localparam logic [6:0]  OP_IMM    = 7'h13;
    localparam logic [6:0]  OP_AUIPC  = 7'h17;
    localparam logic [6:0]  OP_STORE  = 7'h23;
    localparam logic [6:0]  OP_REG    = 7'h33;
    localparam logic [6:0]  OP_LUI    = 7'h37;
    localparam logic [6:0]  OP_BRANCH = 7'h63;
    localparam logic [6:0]  OP_JALR   = 7'h67;
    localparam logic [6:0]  OP_JAL    = 7'h6F;
endpackage

// File: rtl/pc_next.sv
// pc_next: program counter register with next-PC mux (redirect over sequential +4).
// Ports: clk, rst_n (async, active-low), seq_en (+4 step), redirect_en / redirect_pc (jump target),
//        pc (current PC), pc_plus4 (pc + 4, wraps modulo 2^32).
module pc_next #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seq_en,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    assign pc_plus4 = pc + 32'd4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= RESET_PC;
        else if (redirect_en) pc <= redirect_pc;
        else if (seq_en) pc <= pc_plus4;
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM (FETCH/WAIT/HOLD) with one outstanding request and an instruction register.
// Ports: clk, rst_n (async, active-low); imem_req_valid/imem_req_ready/imem_addr request channel;
//        imem_rsp_valid/imem_rsp_data response; instr_valid/instr_ready decode handshake with
//        instr, instr_pc, pc_plus4, opcode, func3, func7_5; redirect_valid/redirect_pc (PCSrc + target);
//        fetch_misalign only when FETCH_MISALIGN_TRAP_EN is defined (otherwise targets are word-aligned).
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic        func7_5,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);
    fetch_state_t state, state_d;
    logic        drop, drop_d, load_instr, seq_en, req_fire, halt, bad_tgt;
    logic [31:0] pc, tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign tgt     = redirect_pc;
    assign bad_tgt = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign halt    = fetch_misalign;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_misalign <= 1'b0;
        else if (bad_tgt) fetch_misalign <= 1'b1;
    end
`else
    assign tgt     = {redirect_pc[31:2], 2'b00};
    assign bad_tgt = 1'b0;
    assign halt    = 1'b0;
`endif
    pc_next #(.RESET_PC(RESET_PC)) u_pc_next (
        .clk         (clk),
        .rst_n       (rst_n),
        .seq_en      (seq_en),
        .redirect_en (redirect_valid),
        .redirect_pc (tgt),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );
    // PC only moves after the held instruction leaves HOLD, so it doubles as instr_pc.
    assign imem_addr = pc;
    assign instr_pc  = pc;
    assign opcode    = instr[6:0];
    assign func3     = instr[14:12];
    assign func7_5   = instr[30];
    assign req_fire  = imem_req_valid && imem_req_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
            drop  <= 1'b0;
            instr <= NOP;
        end else begin
            state <= state_d;
            drop  <= drop_d;
            if (load_instr) instr <= imem_rsp_data;
        end
    end
    // A redirect racing an accepted request leaves that request outstanding, so its response is dropped.
    always_comb begin
        state_d    = state;
        drop_d     = drop;
        load_instr = 1'b0;
        seq_en     = 1'b0;
        case (state)
            ST_FETCH: begin
                state_d = req_fire ? ST_WAIT : ST_FETCH;
                drop_d  = req_fire && redirect_valid;
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_d    = (drop || redirect_valid) ? ST_FETCH : ST_HOLD;
                    drop_d     = 1'b0;
                    load_instr = !(drop || redirect_valid);
                end else if (redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                state_d = (redirect_valid || instr_ready) ? ST_FETCH : ST_HOLD;
                seq_en  = instr_ready && !redirect_valid;
            end
            default: state_d = ST_FETCH;
        endcase
        if (halt || bad_tgt) begin
            state_d    = ST_FETCH;
            drop_d     = 1'b0;
            load_instr = 1'b0;
            seq_en     = 1'b0;
        end
    end
    always_comb begin
        imem_req_valid = rst_n && !halt && (state == ST_FETCH);
        instr_valid    = (state == ST_HOLD);
    end
endmodule
